rst_seq_sync: RTL and testbench
===============================

# rst_seq_sync

Parametrised reset synchronizer and sequencer. It asserts all downstream resets asynchronously and releases them synchronously to `clk_A`. It synchronizes the release through a configurable flip-flop chain, holds for a programmable count, then de-asserts `N_CH` reset channels one at a time with a fixed gap. It sits at the top of each clock domain and drives the per-subsystem active-low resets. It also accepts a synchronous software reset request that re-runs the sequence.

## Interface
- `STAGES`, default 3: synchronizer depth, ≥ 2.
- `N_CH`, default 3: number of sequenced reset channels, ≥ 1.
- `HOLD_CYCLES`, default 4: cycles from HOLD entry to channel 0 release, ≥ 1.
- `GAP_CYCLES`, default 2: cycles between consecutive channel releases, ≥ 1.
- `clk_A`, input, 1: single clock; the block is fully synchronous to it.
- `nrst_in`, input, 1: reset, asynchronous, active-low.
- `sw_rst_req`, input, 1: synchronous software reset request, active-high, sampled on `clk_A` rising edge.
- `nrst_out`, output, `N_CH`: per-channel reset, active-low; bit 0 releases first.
- `seq_done`, output, 1: high once all channels are released.

## Operation
- **Async assert.** `nrst_in` low forces the following, immediately and independent of the clock:
  - all synchronizer flops to 0;
  - `nrst_out` = 0;
  - `seq_done` = 0;
  - FSM = SYNC;
  - counters = 0.
- **Synchronizer.** Chain `sync[0..STAGES-1]`, where `sync[0]` <= 1 and `sync[k]` <= `sync[k-1]`. `sync_ok` = `sync[STAGES-1]`.
- **FSM states:** SYNC, HOLD, RELEASE, DONE.
  - **SYNC:** wait for `sync_ok` = 1, then go to HOLD with `cnt` = 0. `sw_rst_req` is ignored here.
  - **HOLD:** `cnt` increments each cycle.
    - On the edge where `cnt` = HOLD_CYCLES-1: set `nrst_out[0]` = 1, `ch` = 0, `cnt` = 0.
    - Next state is RELEASE, or DONE (with `seq_done` = 1 on the same edge) if `N_CH` = 1.
  - **RELEASE:** `cnt` increments each cycle.
    - On the edge where `cnt` = GAP_CYCLES-1: set `nrst_out[ch+1]` = 1, `ch` += 1, `cnt` = 0.
    - When `ch+1` = N_CH-1, next state is DONE and `seq_done` = 1 on the same edge.
  - **DONE:** hold all outputs high.
- **Software reset.** `sw_rst_req` = 1 sampled in HOLD, RELEASE or DONE takes priority over every other transition. On that edge:
  - `nrst_out` = 0, `seq_done` = 0;
  - FSM = HOLD, `cnt` = 0, `ch` = 0.
  - The synchronizer is untouched.
- **Output monotonicity.** Released channels stay released until `nrst_in` is low or `sw_rst_req` is accepted. Bit i never releases before bit i-1.
- **Arithmetic.**
  - `cnt` width = `$clog2(max(HOLD_CYCLES, GAP_CYCLES)+1)`.
  - `ch` width = `$clog2(N_CH)` (min 1).
  - No wrap: `cnt` is cleared on every transition.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- **Edge numbering.** Edge k is the k-th `clk_A` rising edge after `nrst_in` rises; recovery/removal timing is met.
- **Power-on release.**
  - `sync_ok` rises at edge STAGES.
  - HOLD is entered at edge STAGES+1.
  - `nrst_out[i]` rises at edge STAGES+1+HOLD_CYCLES+i·GAP_CYCLES.
  - `seq_done` rises with `nrst_out[N_CH-1]`.
- **Defaults.**
  - `nrst_out[0]` at edge 8, `nrst_out[1]` at edge 10, `nrst_out[2]` at edge 12.
  - `seq_done` at edge 12.
- **Software reset latency.** If `sw_rst_req` is sampled at edge E:
  - outputs are low after edge E;
  - `nrst_out[i]` rises at E+HOLD_CYCLES+i·GAP_CYCLES.
- **`sw_rst_req` held high:** the sequence restarts every cycle and the outputs stay low.
- **`nrst_in` low mid-sequence or in DONE:** all outputs clear asynchronously. The full sequence, including synchronizer latency, repeats after release.
- **`nrst_in` glitch shorter than a clock period:** still clears everything. The block does not filter.

## Test plan
- **Power-on, defaults.** Release `nrst_in` → `nrst_out` goes 000 → 001 @edge 8 → 011 @10 → 111 @12; `seq_done` = 1 @12; no earlier transitions.
- **Parameter sweep** (STAGES=2, N_CH=1, HOLD_CYCLES=1, GAP_CYCLES=1) → `nrst_out[0]` and `seq_done` both rise at edge 4.
- **Async assert.** Pull `nrst_in` low between edges 10 and 11 (`nrst_out` = 011) → `nrst_out` = 000 and `seq_done` = 0 within the same cycle, without waiting for a clock edge. Release again → `nrst_out[0]` rises at edge 8 of the new release.
- **Software reset in DONE.** Pulse `sw_rst_req` at edge 20 (defaults) → `nrst_out` = 000 after edge 20; 001 @24, 011 @26, 111 @28; `seq_done` @28.
- **Software reset mid-RELEASE.** Pulse at edge 9 → `nrst_out` = 000 after edge 9; `nrst_out[0]` rises @13. Hold `sw_rst_req` high for edges 13-15 → outputs stay 000; release restarts from edge 15.
- **SYNC immunity.** Assert `sw_rst_req` during edges 1-3 → timing is identical to the power-on case.

Source files
------------

// File: rtl/rst_seq_sync.sv
// rtl/rst_seq_sync.sv - reset synchronizer and per-channel release sequencer
//
// Purpose:
//   Asserts all downstream resets asynchronously from nrst_in and releases
//   them synchronously to clk_A. Release passes through a STAGES-deep
//   synchronizer, waits HOLD_CYCLES, then frees N_CH channels one at a time,
//   GAP_CYCLES apart. A synchronous software request re-runs the sequence
//   from HOLD without touching the synchronizer.
//
// Ports:
//   clk_A       in   1     clock
//   nrst_in     in   1     asynchronous active-low reset
//   sw_rst_req  in   1     synchronous software reset request, active-high
//   nrst_out    out  N_CH  per-channel active-low reset, bit 0 releases first
//   seq_done    out  1     high once every channel is released

module rst_seq_sync #(
  parameter int STAGES      = 3,
  parameter int N_CH        = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic            clk_A,
  input  logic            nrst_in,
  input  logic            sw_rst_req,
  output logic [N_CH-1:0] nrst_out,
  output logic            seq_done
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SYNC    = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state;
  logic [STAGES-1:0] sync;
  logic [CNT_W-1:0]  cnt;
  logic [CH_W-1:0]   ch;
  logic              sync_ok;

  assign sync_ok = sync[STAGES-1];

  always_ff @(posedge clk_A or negedge nrst_in) begin
    if (!nrst_in) begin
      sync     <= '0;
      state    <= S_SYNC;
      cnt      <= '0;
      ch       <= '0;
      nrst_out <= '0;
      seq_done <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], 1'b1};

      // Software request wins over every transition once past SYNC; the
      // synchronizer has already settled so the sequence restarts at HOLD.
      if (state != S_SYNC && sw_rst_req) begin
        state    <= S_HOLD;
        cnt      <= '0;
        ch       <= '0;
        nrst_out <= '0;
        seq_done <= 1'b0;
      end else begin
        case (state)
          S_SYNC: begin
            if (sync_ok) begin
              state <= S_HOLD;
              cnt   <= '0;
            end
          end

          S_HOLD: begin
            if (cnt == HOLD_LAST) begin
              nrst_out <= N_CH'(1);
              ch       <= '0;
              cnt      <= '0;
              if (N_CH == 1) begin
                state    <= S_DONE;
                seq_done <= 1'b1;
              end else begin
                state <= S_RELEASE;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          S_RELEASE: begin
            if (cnt == GAP_LAST) begin
              // Released bits form a thermometer from bit 0, so shifting the
              // current mask left by one and OR-ing frees exactly bit ch+1.
              nrst_out <= nrst_out | (nrst_out << 1);
              ch       <= ch + CH_W'(1);
              cnt      <= '0;
              if (int'(ch) + 1 == N_CH - 1) begin
                state    <= S_DONE;
                seq_done <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          S_DONE: begin
          end

          default: begin
            state <= S_SYNC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rst_seq_sync.sv
// tb/tb_rst_seq_sync.sv - directed plus random check of rst_seq_sync against a release-time model

module tb_rst_seq_sync;

  localparam int STG0 = 3, NCH0 = 3, HOLD0 = 4, GAP0 = 2;
  localparam int STG1 = 2, NCH1 = 1, HOLD1 = 1, GAP1 = 1;

  logic            clk_A = 1'b0;
  logic            nrst_in = 1'b0;
  logic            sw_rst_req = 1'b0;
  logic [NCH0-1:0] nrst_out0;
  logic            seq_done0;
  logic [NCH1-1:0] nrst_out1;
  logic            seq_done1;

  int total = 0;
  int bad   = 0;

  // Model state: e = edges since nrst_in rose, h0/h1 = edge at which HOLD
  // was (re)entered for each instance.
  int e  = 0;
  int h0 = STG0 + 1;
  int h1 = STG1 + 1;

  always #5 clk_A = ~clk_A;

  rst_seq_sync #(.STAGES(STG0), .N_CH(NCH0), .HOLD_CYCLES(HOLD0), .GAP_CYCLES(GAP0)) dut0 (
    .clk_A(clk_A), .nrst_in(nrst_in), .sw_rst_req(sw_rst_req),
    .nrst_out(nrst_out0), .seq_done(seq_done0)
  );

  rst_seq_sync #(.STAGES(STG1), .N_CH(NCH1), .HOLD_CYCLES(HOLD1), .GAP_CYCLES(GAP1)) dut1 (
    .clk_A(clk_A), .nrst_in(nrst_in), .sw_rst_req(sw_rst_req),
    .nrst_out(nrst_out1), .seq_done(seq_done1)
  );

  // Channel i is released once hold + i*gap edges have elapsed since HOLD entry.
  function automatic logic [31:0] exp_vec(int edge_n, int h, int hold, int gap, int nch);
    logic [31:0] v = '0;
    for (int i = 0; i < nch; i++)
      if (edge_n >= h + hold + i * gap) v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] x0, x1;
    x0 = exp_vec(e, h0, HOLD0, GAP0, NCH0);
    x1 = exp_vec(e, h1, HOLD1, GAP1, NCH1);
    check("nrst_out0", 32'(nrst_out0), x0);
    check("seq_done0", 32'(seq_done0), 32'(x0[NCH0-1]));
    check("nrst_out1", 32'(nrst_out1), x1);
    check("seq_done1", 32'(seq_done1), 32'(x1[NCH1-1]));
  endtask

  task automatic model_reset();
    e  = 0;
    h0 = STG0 + 1;
    h1 = STG1 + 1;
  endtask

  // Called at a falling edge: drive sw, take one rising edge, check at next fall.
  task automatic step(input logic sw);
    sw_rst_req = sw;
    @(posedge clk_A);
    e++;
    if (sw && e >= STG0 + 2) h0 = e;
    if (sw && e >= STG1 + 2) h1 = e;
    @(negedge clk_A);
    check_all();
  endtask

  // Pull nrst_in low between edges and confirm clearing without a clock edge.
  task automatic async_pulse(input int low_ns);
    nrst_in = 1'b0;
    #1;
    model_reset();
    check("async_clear0", {31'(0), seq_done0} | 32'(nrst_out0), 32'd0);
    check("async_clear1", {31'(0), seq_done1} | 32'(nrst_out1), 32'd0);
    #(low_ns);
    nrst_in = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk_A);
    check_all();

    // Power-on with defaults, then software reset in DONE at edge 20.
    nrst_in = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step(1'b0);
      if (k == 12) check("poweron_e12", 32'(nrst_out0), 32'b111);
    end
    step(1'b1);
    check("swdone_e20", 32'(nrst_out0), 32'b000);
    for (int k = 21; k <= 30; k++) step(1'b0);

    // Async assert between edges 10 and 11, rerun with sw pulse at edge 9
    // and sw held across edges 13-15.
    model_reset();
    nrst_in = 1'b0;
    @(negedge clk_A);
    nrst_in = 1'b1;
    for (int k = 1; k <= 10; k++) step(1'b0);
    check("pre_async_e10", 32'(nrst_out0), 32'b011);
    async_pulse(2);
    for (int k = 1; k <= 20; k++) step(k == 9 || (k >= 13 && k <= 15));

    // Software request during SYNC is ignored.
    async_pulse(2);
    for (int k = 1; k <= 14; k++) begin
      step(k <= 3);
      if (k == 8) check("syncimm_e8", 32'(nrst_out0), 32'b001);
    end

    // Random sw requests and short nrst_in glitches.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 39) == 0) async_pulse(int'($urandom_range(1, 3)));
      step($urandom_range(0, 11) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
